// File: rtl/music_playback_ctrl_pkg.sv
// Shared constants and state encoding for the music sample playback controller.
// Optional feature macro used by this codebase slice: MUSIC_VOLUME_EN.
package music_pkg;

    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 17;
    localparam int LAST_ADDR    = 54831;
    localparam int TICK_DIV_DEF = 1042;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FETCH,
        LATCH,
        HOLD,
        PAUSED
    } play_state_e;

endpackage

// File: rtl/music_playback_ctrl_if.sv
// Command, ROM and codec-stream signals of the playback controller in one bundle.
// With MUSIC_VOLUME_EN defined the bundle also carries the vol attenuation input.
interface music_playback_ctrl_if;
    import music_pkg::*;

    logic              play;
    logic              pause;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;
    logic              playing;
    logic              done;
    logic              underrun;
`ifdef MUSIC_VOLUME_EN
    logic [2:0]        vol;
`endif

    modport master (
        input  play, pause, stop, loop_en, rom_data, sample_ready,
`ifdef MUSIC_VOLUME_EN
        input  vol,
`endif
        output rom_addr, sample_out, sample_valid, playing, done, underrun
    );

    modport slave (
        output play, pause, stop, loop_en, rom_data, sample_ready,
`ifdef MUSIC_VOLUME_EN
        output vol,
`endif
        input  rom_addr, sample_out, sample_valid, playing, done, underrun
    );

endinterface

// File: rtl/music_playback_ctrl_sample_tick_gen.sv
// Sample-rate tick: counts 0..TICK_DIV-1 while run is high, tick on the final count.
// clear forces the count back to 0; the count is frozen while run is low.
module sample_tick_gen #(
    parameter int TICK_DIV = 1042
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int            CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/music_playback_ctrl.sv
// Music ROM playback sequencer: paces ROM reads on the sample tick and streams words to the codec.
// MUSIC_VOLUME_EN adds an arithmetic right-shift attenuation of each captured word.
//
// state  | meaning
// IDLE   | stopped, address 0, waiting for play
// WAIT   | waiting for the next sample tick
// FETCH  | ROM read in flight at the current address
// LATCH  | capture ROM word into the output register
// HOLD   | sample offered to codec, waiting for handshake
// PAUSED | playback held, tick counter frozen
module music_playback_ctrl
    import music_pkg::*;
#(
    parameter int TICK_DIV  = music_pkg::TICK_DIV_DEF,
    parameter int LAST_ADDR = music_pkg::LAST_ADDR
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    music_playback_ctrl_if.master  bus
);

    play_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
    logic              playing;
    logic              tick;
    logic              tick_run;
    logic              tick_clear;
    logic              handshake;
    logic              at_last;

    assign handshake  = valid_q && bus.sample_ready;
    assign at_last    = (rom_addr_q == ADDR_W'(LAST_ADDR));
    assign tick_run   = (state_q != IDLE) && (state_q != PAUSED);
    // Counter restarts from 0 whenever playback begins from IDLE.
    assign tick_clear = bus.stop || (state_q == IDLE);

    sample_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .run     (tick_run),
        .clear   (tick_clear),
        .tick    (tick)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.play && !bus.pause) state_d = WAIT;
                WAIT: begin
                    if (bus.pause)   state_d = PAUSED;
                    else if (tick)   state_d = FETCH;
                end
                FETCH:   state_d = LATCH;
                LATCH:   state_d = HOLD;
                HOLD: begin
                    if (handshake) begin
                        if (at_last)        state_d = bus.loop_en ? WAIT : IDLE;
                        else if (bus.pause) state_d = PAUSED;
                        else                state_d = WAIT;
                    end
                end
                PAUSED:  if (bus.play && !bus.pause) state_d = WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        playing    = (state_q != IDLE) && (state_q != PAUSED);
        rom_addr_d = rom_addr_q;
        sample_d   = sample_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        if (bus.stop) begin
            rom_addr_d = '0;
            valid_d    = 1'b0;
            underrun_d = 1'b0;
        end else begin
            case (state_q)
                LATCH: begin
`ifdef MUSIC_VOLUME_EN
                    sample_d = $signed(bus.rom_data) >>> bus.vol;
`else
                    sample_d = bus.rom_data;
`endif
                    valid_d  = 1'b1;
                end
                HOLD: begin
                    if (tick) underrun_d = 1'b1;
                    if (handshake) begin
                        valid_d = 1'b0;
                        if (at_last) begin
                            rom_addr_d = '0;
                            done_d     = !bus.loop_en;
                        end else begin
                            rom_addr_d = rom_addr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.playing      = playing;
    assign bus.done         = done_q;
    assign bus.underrun     = underrun_q;

endmodule

// File: tb/tb_music_playback_ctrl.sv
// Scoreboard bench for music_playback_ctrl with TICK_DIV=8, LAST_ADDR=5 and a ROM holding word i = i*3.
module tb_music_playback_ctrl;
    import music_pkg::*;

    localparam int TB_TICK = 8;
    localparam int TB_LAST = 5;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                gap;
    } exp_t;

    logic clk;
    logic Reset_n;
    logic rom_ovr;
    int   checks;
    int   fails;
    int   cyc;
    int   pops;
    int   last_hs;
    exp_t exp_q[$];

    music_playback_ctrl_if m_if ();

    music_playback_ctrl #(
        .TICK_DIV  (TB_TICK),
        .LAST_ADDR (TB_LAST)
    ) dut (
        .Clk     (clk),
        .Reset_n (Reset_n),
        .bus     (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        m_if.rom_data <= rom_ovr ? DATA_W'(17'h1FFF8) : DATA_W'(m_if.rom_addr * 3);

    // Monitor: every accepted sample is checked against the head of the expectation queue.
    always @(negedge clk) begin
        if (Reset_n && m_if.sample_valid && m_if.sample_ready && !m_if.stop) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_sample got=%0d want=none", m_if.sample_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m_if.sample_out !== e.data) begin
                    fails++;
                    $display("FAIL sample_data got=%0d want=%0d", m_if.sample_out, e.data);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_hs != e.gap) begin
                        fails++;
                        $display("FAIL sample_spacing got=%0d want=%0d", cyc - last_hs, e.gap);
                    end
                end
            end
            last_hs = cyc;
            pops++;
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int data, input int gap);
        exp_t e;
        e.data = DATA_W'(data);
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic pulse_play();
        m_if.play = 1'b1;
        step();
        m_if.play = 1'b0;
    endtask

    task automatic do_stop();
        m_if.stop = 1'b1;
        step();
        m_if.stop = 1'b0;
        m_if.play = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            step();
            n++;
        end
        if (pops < target) check({name, "_timeout"}, pops, target);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (!m_if.sample_valid && n < budget) begin
            step();
            n++;
        end
        if (!m_if.sample_valid) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int done_cnt, done_cyc, bad, base;
        checks = 0; fails = 0; cyc = 0; pops = 0; last_hs = 0; rom_ovr = 1'b0;
        Reset_n = 1'b0;
        m_if.play = 1'b0; m_if.pause = 1'b0; m_if.stop = 1'b0;
        m_if.loop_en = 1'b0; m_if.sample_ready = 1'b0;
`ifdef MUSIC_VOLUME_EN
        m_if.vol = 3'd0;
`endif
        step(); step();
        check("rst_rom_addr", m_if.rom_addr, 0);
        check("rst_sample_out", m_if.sample_out, 0);
        check("rst_valid", m_if.sample_valid, 0);
        check("rst_done", m_if.done, 0);
        check("rst_underrun", m_if.underrun, 0);
        check("rst_playing", m_if.playing, 0);
        check("rst_state", dut.state_q, IDLE);
        Reset_n = 1'b1;
        m_if.sample_ready = 1'b1;
        step();

        // Single pass, no loop.
        for (int i = 0; i <= TB_LAST; i++) push(i * 3, (i == 0) ? 0 : TB_TICK);
        base = pops;
        pulse_play();
        done_cnt = 0; done_cyc = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (m_if.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        check("pass_count", pops - base, TB_LAST + 1);
        check("done_pulses", done_cnt, 1);
        check("done_timing", done_cyc, last_hs + 1);
        check("pass_end_addr", m_if.rom_addr, 0);
        check("pass_end_state", dut.state_q, IDLE);

        // Looping: 14 samples wrap from 15 back to 0.
        m_if.loop_en = 1'b1;
        for (int i = 0; i < 14; i++) push((i % (TB_LAST + 1)) * 3, (i == 0) ? 0 : TB_TICK);
        base = pops;
        pulse_play();
        done_cnt = 0; bad = 0;
        for (int n = 0; n < 14 * TB_TICK + 20 && pops < base + 14; n++) begin
            step();
            if (m_if.done) done_cnt++;
            if (!m_if.playing) bad++;
        end
        check("loop_count", pops - base, 14);
        check("loop_no_done", done_cnt, 0);
        check("loop_not_playing_cycles", bad, 0);
        do_stop();
        m_if.loop_en = 1'b0;
        check("loop_stop_state", dut.state_q, IDLE);

        // Codec stall: held sample stays put, ticks in HOLD flag underrun.
        m_if.sample_ready = 1'b0;
        push(0, 0);
        base = pops;
        pulse_play();
        wait_valid(30, "stall_valid");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!m_if.sample_valid || m_if.sample_out != 0) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_underrun", m_if.underrun, 1);
        m_if.sample_ready = 1'b1;
        step();
        check("stall_delivered", pops - base, 1);
        check("underrun_sticky", m_if.underrun, 1);
        do_stop();
        check("stop_clears_underrun", m_if.underrun, 0);
        check("stop_clears_valid", m_if.sample_valid, 0);

        // Pause in WAIT at address 2.
        push(0, 0);
        push(3, TB_TICK);
        base = pops;
        pulse_play();
        wait_pops(base + 2, 40, "pause_pre");
        check("pause_start_addr", m_if.rom_addr, 2);
        m_if.pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (m_if.rom_addr != 2 || m_if.playing || m_if.sample_valid) bad++;
        end
        check("pause_hold", bad, 0);
        check("pause_state", dut.state_q, PAUSED);
        push(6, 0);
        m_if.pause = 1'b0;
        pulse_play();
        wait_pops(base + 3, 30, "pause_resume");
        do_stop();

        // Stop wins over play while a sample is held.
        m_if.sample_ready = 1'b0;
        m_if.play = 1'b1;
        wait_valid(30, "stop_hold_valid");
        check("stop_hold_pre_state", dut.state_q, HOLD);
        m_if.stop = 1'b1;
        step();
        check("stop_hold_state", dut.state_q, IDLE);
        check("stop_hold_valid", m_if.sample_valid, 0);
        check("stop_hold_addr", m_if.rom_addr, 0);
        m_if.stop = 1'b0;
        m_if.play = 1'b0;
        step();

`ifdef MUSIC_VOLUME_EN
        rom_ovr = 1'b1;
        m_if.vol = 3'd1;
        pulse_play();
        wait_valid(30, "vol_valid");
        check("vol_shift", m_if.sample_out, 17'h1FFFC);
        do_stop();
        rom_ovr = 1'b0;
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
